// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory, big-endian, one byte per cycle.
// Optional per-load word checksum outputs are enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    input  logic [CNT_W-1:0]  WORD_COUNT,
    input  logic              IN_VALID,
    input  logic [31:0]       IN_DATA,
    output logic              IN_READY,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_WDATA,
    output logic              BUSY,
    output logic              DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       CHECKSUM,
    output logic              CHECKSUM_VALID
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, FINISH} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic [1:0]        idx_reg, idx_next;
    logic [31:0]       word_reg, word_next;
    logic              in_ready_reg, in_ready_next;
    logic              mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [7:0]        mem_wdata_reg, mem_wdata_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              handshake;
    logic [ADDR_W-1:0] base_aligned;
    logic [7:0]        word_bytes [4];

    // Byte 0 is the most significant byte: big-endian layout in memory.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[31-8*gi -: 8];
        end
    endgenerate

    assign handshake    = (state_reg == WAIT_WORD) && in_ready_reg && IN_VALID;
    assign base_aligned = BASE_ADDR & {{(ADDR_W-2){1'b1}}, 2'b00};

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            idx_reg       <= '0;
            word_reg      <= '0;
            in_ready_reg  <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            remaining_reg <= remaining_next;
            idx_reg       <= idx_next;
            word_reg      <= word_next;
            in_ready_reg  <= in_ready_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        remaining_next = remaining_reg;
        idx_next       = idx_reg;
        word_next      = word_reg;
        in_ready_next  = in_ready_reg;
        mem_we_next    = 1'b0;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    addr_next      = base_aligned;
                    remaining_next = WORD_COUNT;
                    if (WORD_COUNT != '0) begin
                        state_next    = WAIT_WORD;
                        in_ready_next = 1'b1;
                        busy_next     = 1'b1;
                    end else begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end
                end
            end
            WAIT_WORD: begin
                if (handshake) begin
                    // First byte goes out straight from the bus so writes start next cycle.
                    word_next      = IN_DATA;
                    in_ready_next  = 1'b0;
                    idx_next       = 2'd0;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = addr_reg;
                    mem_wdata_next = IN_DATA[31:24];
                    state_next     = WRITE;
                end
            end
            WRITE: begin
                if (idx_reg != 2'd3) begin
                    idx_next       = idx_reg + 2'd1;
                    mem_we_next    = 1'b1;
                    mem_addr_next  = addr_reg + ADDR_W'(idx_next);
                    mem_wdata_next = word_bytes[idx_next];
                end else begin
                    idx_next       = 2'd0;
                    addr_next      = addr_reg + ADDR_W'(4);
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = FINISH;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next    = WAIT_WORD;
                        in_ready_next = 1'b1;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign IN_READY  = in_ready_reg;
    assign MEM_WE    = mem_we_reg;
    assign MEM_ADDR  = mem_addr_reg;
    assign MEM_WDATA = mem_wdata_reg;
    assign BUSY      = busy_reg;
    assign DONE      = done_reg;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_reg;
    logic        checksum_valid_reg;

    // Sum updates at the handshake, so it is already final when DONE rises.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            checksum_reg       <= '0;
            checksum_valid_reg <= 1'b0;
        end else if (state_reg == IDLE && START) begin
            checksum_reg       <= '0;
            checksum_valid_reg <= (WORD_COUNT == '0);
        end else begin
            if (handshake) begin
                checksum_reg <= checksum_reg + IN_DATA;
            end
            if (done_next) begin
                checksum_valid_reg <= 1'b1;
            end
        end
    end

    assign CHECKSUM       = checksum_reg;
    assign CHECKSUM_VALID = checksum_valid_reg;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected byte writes are queued at each handshake and
// popped as MEM_WE appears; a byte-array memory model supports word fetch checks.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b0;
    logic              START = 1'b0;
    logic [ADDR_W-1:0] BASE_ADDR = '0;
    logic [CNT_W-1:0]  WORD_COUNT = '0;
    logic              IN_VALID = 1'b0;
    logic [31:0]       IN_DATA = '0;
    logic              IN_READY;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [7:0]        MEM_WDATA;
    logic              BUSY;
    logic              DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]       CHECKSUM;
    logic              CHECKSUM_VALID;
`endif

    imem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .BASE_ADDR(BASE_ADDR),
        .WORD_COUNT(WORD_COUNT), .IN_VALID(IN_VALID), .IN_DATA(IN_DATA),
        .IN_READY(IN_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .BUSY(BUSY), .DONE(DONE)
`ifdef IMEM_LOADER_CHECKSUM_EN
        , .CHECKSUM(CHECKSUM), .CHECKSUM_VALID(CHECKSUM_VALID)
`endif
    );

    always #5 CLK = ~CLK;

    int vec_count = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_we_cyc = 0;
    int hs_cyc = 0;
    int we_run = 0;
    int exp_addr = 0;
    logic [ADDR_W+7:0] exp_q [$];
    logic [7:0] imem [DEPTH];

    task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] fetch(input int a);
        return {imem[a & (DEPTH-1)], imem[(a+1) & (DEPTH-1)],
                imem[(a+2) & (DEPTH-1)], imem[(a+3) & (DEPTH-1)]};
    endfunction

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (MEM_WE) imem[MEM_ADDR] <= MEM_WDATA;
    end

    // Write monitor: pops the scoreboard and checks each word is written as an unbroken 4-byte run.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            we_run = 0;
        end else if (MEM_WE) begin
            logic [ADDR_W+7:0] e;
            we_run++;
            last_we_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_equal("we_unexpected", 32'(MEM_ADDR), 32'hFFFFFFFF);
            end else begin
                e = exp_q.pop_front();
                check_equal("wr_addr", 32'(MEM_ADDR), 32'(e[ADDR_W+7:8]));
                check_equal("wr_data", 32'(MEM_WDATA), 32'(e[7:0]));
                $display("write addr=%03h data=%02h", MEM_ADDR, MEM_WDATA);
            end
        end else if (we_run != 0) begin
            check_equal("we_run_len", we_run, 4);
            we_run = 0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load(input int base, input int count);
        START = 1'b1;
        BASE_ADDR = ADDR_W'(base);
        WORD_COUNT = CNT_W'(count);
        exp_addr = base & (DEPTH-4);
        tick();
        START = 1'b0;
        BASE_ADDR = ADDR_W'($urandom);
        WORD_COUNT = CNT_W'($urandom);
        $display("start base=%03h count=%0d", base, count);
        if (count != 0) begin
            check_equal("busy_after_start", 32'(BUSY), 1);
            check_equal("ready_after_start", 32'(IN_READY), 1);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        bit ok = 0;
        IN_VALID = 1'b1;
        IN_DATA = w;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = IN_READY;
            tick();
        end
        IN_VALID = 1'b0;
        IN_DATA = $urandom;
        if (!ok) begin
            check_equal("hs_timeout", 0, 1);
        end else begin
            hs_cyc = cyc;
            for (int b = 0; b < 4; b++) begin
                logic [7:0] by;
                by = w[31-8*b -: 8];
                exp_q.push_back({ADDR_W'((exp_addr + b) & (DEPTH-1)), by});
            end
            exp_addr = (exp_addr + 4) & (DEPTH-1);
            $display("handshake word=%08h cycle=%0d", w, hs_cyc);
        end
    endtask

    task automatic wait_done(input bit had_writes, output int waited);
        bit ok = 0;
        waited = 0;
        while (!ok && waited < 100) begin
            if (DONE) ok = 1;
            else begin
                tick();
                waited++;
            end
        end
        check_equal("done_seen", 32'(ok), 1);
        if (ok) begin
            check_equal("busy_at_done", 32'(BUSY), 0);
            check_equal("ready_at_done", 32'(IN_READY), 0);
            if (had_writes) check_equal("done_latency", cyc - last_we_cyc, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            check_equal("csum_valid_at_done", 32'(CHECKSUM_VALID), 1);
`endif
            tick();
            check_equal("done_one_cycle", 32'(DONE), 0);
            check_equal("busy_after_done", 32'(BUSY), 0);
        end
        check_equal("sb_empty", exp_q.size(), 0);
        $display("done after %0d cycles", waited);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int h0;
        #3;
        check_equal("rst_ready", 32'(IN_READY), 0);
        check_equal("rst_we", 32'(MEM_WE), 0);
        check_equal("rst_busy", 32'(BUSY), 0);
        check_equal("rst_done", 32'(DONE), 0);
        check_equal("rst_addr", 32'(MEM_ADDR), 0);
        check_equal("rst_wdata", 32'(MEM_WDATA), 0);
        tick();
        RESET_N = 1'b1;
        tick();

        // Single word at address 0.
        start_load(0, 1);
        send_word(32'h00011020);
        wait_done(1, w);
        check_equal("fetch_0", fetch(0), 32'h00011020);

        // Back-to-back burst: handshakes every 5 cycles.
        start_load('h10, 3);
        send_word(32'hA1A2A3A4);
        h0 = hs_cyc;
        send_word(32'hB1B2B3B4);
        check_equal("hs_spacing_1", hs_cyc - h0, 5);
        h0 = hs_cyc;
        send_word(32'hC1C2C3C4);
        check_equal("hs_spacing_2", hs_cyc - h0, 5);
        wait_done(1, w);
        check_equal("fetch_10", fetch('h10), 32'hA1A2A3A4);
        check_equal("fetch_14", fetch('h14), 32'hB1B2B3B4);
        check_equal("fetch_18", fetch('h18), 32'hC1C2C3C4);

        // Producer stalls for 3 cycles between words; IN_READY must hold.
        start_load('h20, 2);
        send_word(32'h12345678);
        for (int i = 0; i < 7; i++) tick();
        check_equal("ready_held", 32'(IN_READY), 1);
        send_word(32'h9ABCDEF0);
        wait_done(1, w);
        check_equal("fetch_24", fetch('h24), 32'h9ABCDEF0);

        // Zero-length load.
        start_load('h40, 0);
        wait_done(0, w);
        check_equal("count0_latency", w, 0);

        // Unaligned base is forced down to a word boundary.
        start_load('h3FE, 1);
        send_word(32'hDEADBEEF);
        wait_done(1, w);
        check_equal("fetch_3fc", fetch('h3FC), 32'hDEADBEEF);

        // Wrap past the top; START pulsed while busy must be ignored.
        start_load('h3FC, 2);
        send_word(32'h0BADF00D);
        START = 1'b1;
        BASE_ADDR = ADDR_W'('h100);
        WORD_COUNT = CNT_W'(5);
        tick();
        START = 1'b0;
        send_word(32'hCAFEBABE);
        wait_done(1, w);
        check_equal("fetch_wrap_3fc", fetch('h3FC), 32'h0BADF00D);
        check_equal("fetch_wrap_000", fetch(0), 32'hCAFEBABE);

        // Checksum accumulation with 32-bit wrap.
        start_load('h200, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_equal("csum_cleared", CHECKSUM, 0);
        check_equal("csum_valid_cleared", 32'(CHECKSUM_VALID), 0);
`endif
        send_word(32'h00000001);
        send_word(32'h00000002);
        send_word(32'hFFFFFFFF);
        wait_done(1, w);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_equal("csum_value", CHECKSUM, 32'h00000002);
        check_equal("csum_valid_held", 32'(CHECKSUM_VALID), 1);
`endif
        check_equal("fetch_208", fetch('h208), 32'hFFFFFFFF);

        // Asynchronous reset in the middle of a word write.
        start_load('h80, 1);
        send_word(32'h55AA55AA);
        tick();
        check_equal("mid_write_we", 32'(MEM_WE), 1);
        RESET_N = 1'b0;
        #1;
        exp_q.delete();
        check_equal("arst_ready", 32'(IN_READY), 0);
        check_equal("arst_we", 32'(MEM_WE), 0);
        check_equal("arst_busy", 32'(BUSY), 0);
        check_equal("arst_done", 32'(DONE), 0);
        check_equal("arst_addr", 32'(MEM_ADDR), 0);
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        check_equal("idle_ready", 32'(IN_READY), 0);
        check_equal("idle_busy", 32'(BUSY), 0);

        // Recovery load after reset.
        start_load('h84, 1);
        send_word(32'h13579BDF);
        wait_done(1, w);
        check_equal("fetch_84", fetch('h84), 32'h13579BDF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end
endmodule
